// File: rtl/id_ex_pipe_reg.sv
// ============================================================================
// id_ex_pipe_reg : elastic ID->EX pipeline register, one-entry skid buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ALUC_W = 4,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wreg,
  input  logic              m2reg,
  input  logic              wmem,
  input  logic              shift,
  input  logic              aluimm,
  input  logic [ALUC_W-1:0] aluc,
  input  logic [REG_AW-1:0] wn,
  input  logic [DATA_W-1:0] qa,
  input  logic [DATA_W-1:0] qb,
  input  logic [DATA_W-1:0] immeOrSa,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              EXwreg,
  output logic              EXm2reg,
  output logic              EXwmem,
  output logic              EXshift,
  output logic              EXaluimm,
  output logic [ALUC_W-1:0] EXaluc,
  output logic [REG_AW-1:0] EXwn,
  output logic [DATA_W-1:0] EXqa,
  output logic [DATA_W-1:0] EXqb,
  output logic [DATA_W-1:0] EXimmeOrSa,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int BW = 5 + ALUC_W + REG_AW + 3 * DATA_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    m_q, m_d;
  logic [BW-1:0]    s_q, s_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    in_bundle;
  logic             accept;
  logic             drain;
  logic             m_wreg, m_m2reg, m_wmem;

  assign in_bundle = {wreg, m2reg, wmem, shift, aluimm, aluc, wn, qa, qb, immeOrSa};

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          m_d     = in_bundle;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          m_d = in_bundle;
        end else if (accept) begin
          state_d = ST_FULL;
          s_d     = in_bundle;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_d = ST_ONE;
          m_d     = s_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A redirect drops everything; held payload becomes don't-care behind out_valid=0.
    if (flush) begin
      state_d = ST_EMPTY;
      m_d     = m_q;
      s_d     = s_q;
    end
    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= (state_d != ST_FULL);
      cnt_q      <= cnt_d;
    end
  end

  assign {m_wreg, m_m2reg, m_wmem, EXshift, EXaluimm, EXaluc, EXwn,
          EXqa, EXqb, EXimmeOrSa} = m_q;

  // Side-effecting controls must never leak out of a bubble.
  assign EXwreg    = m_wreg  & out_valid;
  assign EXm2reg   = m_m2reg & out_valid;
  assign EXwmem    = m_wmem  & out_valid;
  assign stall_cnt = cnt_q;

endmodule

`default_nettype wire

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised, elastic ID->EX pipeline register for the 5-stage CPU.
- Carries the decode control and operand bundle: wreg, m2reg, wmem, shift, aluimm, aluc, wn, qa, qb, immeOrSa.
- Uses a valid/ready handshake with a one-entry skid buffer, so the EX-side stall does not reach ID combinationally.
- Adds flush (bubble insert on branch/jump redirect) and a saturating stall-cycle counter for performance debug.

Parameters:
DATA_W, 32, width of qa, qb, immeOrSa
ALUC_W, 4, width of aluc
REG_AW, 5, width of destination register number wn
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock; all state updates on rising edge
clr  in  1  synchronous, active-high reset
flush  in  1  discard all held entries (redirect from branch resolve)
in_valid  in  1  ID presents a valid instruction bundle
in_ready  out  1  register can accept this cycle
wreg, m2reg, wmem, shift, aluimm  in  1 each  ID control bits
aluc  in  ALUC_W  ALU operation
wn  in  REG_AW  destination register
qa, qb, immeOrSa  in  DATA_W each  operands / immediate-or-shamt
out_valid  out  1  EX bundle valid
out_ready  in  1  EX consumes bundle this cycle
EXwreg, EXm2reg, EXwmem, EXshift, EXaluimm  out  1 each  registered control
EXaluc  out  ALUC_W  registered aluc
EXwn  out  REG_AW  registered wn
EXqa, EXqb, EXimmeOrSa  out  DATA_W each  registered operands
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S. Each entry holds the full bundle plus a valid bit.
- States:
  - EMPTY: M invalid, S invalid.
  - ONE: M valid, S invalid.
  - FULL: M valid, S valid.
- Handshake:
  - in_ready = !S.valid, driven directly from a flop; no combinational path from out_ready.
  - out_valid = M.valid.
  - Accept: in_valid & in_ready.
  - Drain: out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY + accept -> ONE; M loads the input.
  - ONE + accept & drain -> ONE; M loads the input.
  - ONE + accept & !drain -> FULL; S loads the input.
  - ONE + !accept & drain -> EMPTY.
  - FULL + drain -> ONE; M <= S. No accept is possible in FULL because in_ready=0.
  - Otherwise the state is held.
- Ordering: strict FIFO. Bundles leave in acceptance order; no loss, no duplication.
- Flush: flush=1 -> next state EMPTY. An accept in the same cycle is discarded. An in-progress drain completes at the EX side in the current cycle, since EX already sampled it.
- Bubble safety: EXwreg, EXm2reg and EXwmem are forced to 0 whenever out_valid=0. The other outputs hold their last value, and that value is don't-care when invalid.
- Latency: 1 cycle from accept to out_valid when the block was EMPTY or was draining M.
- Reset (clr=1, synchronous): state EMPTY, in_ready=1 after the edge, stall_cnt=0, all EX* outputs 0. Reset overrides flush and handshake. Reset mid-FULL drops both entries.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by clr; flush does not clear it.
- Width rule: all fields are transferred bit-exact; no sign or zero extension inside this block.

Test Plan:
- Reset: hold clr 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, all EX*=0, stall_cnt=0.
- Streaming: out_ready=1; send 4 bundles with qa=1..4, wn=1..4 on consecutive cycles -> out_valid one cycle later each; EXqa=1,2,3,4 in order; in_ready stays 1.
- Backpressure: out_ready=0; send A (qa=0xA), then B (qa=0xB) -> state FULL, in_ready=0, EXqa=0xA; third bundle C is held off. Raise out_ready -> A, B, C emerge in order; stall_cnt equals the number of stalled cycles.
- Flush: FULL with A, B; pulse flush with in_valid=1 carrying C -> next cycle out_valid=0, EXwreg=EXwmem=EXm2reg=0, in_ready=1; C is never output.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Mid-operation reset: FULL, assert clr for 1 cycle together with out_ready=1 -> EMPTY, no bundle emitted after the edge, stall_cnt=0.
